// File: rtl/tl_pkg.sv
// Transaction-layer shared types, completion constants and the completion header builder.
package tl_pkg;

   localparam logic [2:0] FMT_CPL  = 3'b000;
   localparam logic [2:0] FMT_CPLD = 3'b010;
   localparam logic [4:0] TYPE_CPL = 5'b01010;

   localparam logic [2:0] CPL_SC = 3'd0;
   localparam logic [2:0] CPL_UR = 3'd1;
   localparam logic [2:0] CPL_CA = 3'd2;

   typedef struct packed {
      logic [15:0]  requester_id;
      logic [7:0]   tag;
      logic [6:0]   lower_addr;
      logic [11:0]  byte_count;
      logic [2:0]   cpl_status;
      logic         has_data;
      logic [255:0] data;
   } cpl_gen_cmd_t;

   typedef struct packed {
      logic [127:0] data;
      logic         sop;
      logic         eop;
      logic [3:0]   be;
      logic         is_dllp;
   } tl_stream_t;

   typedef struct packed {
      logic [7:0]  ph;
      logic [11:0] pd;
      logic [7:0]  nph;
      logic [11:0] npd;
      logic [7:0]  cplh;
      logic [11:0] cpld;
   } tl_credit_t;

   // 3DW completion header {DW0, DW1, DW2}; a non-zero length selects CplD.
   function automatic logic [95:0] build_cpl_hdr(
      input logic [15:0] cid,
      input logic [2:0]  status,
      input logic [11:0] byte_count,
      input logic [15:0] requester_id,
      input logic [7:0]  tag,
      input logic [6:0]  lower_addr,
      input logic [9:0]  len
   );
      logic [31:0] dw0, dw1, dw2;
      dw0 = {(len != 10'd0) ? FMT_CPLD : FMT_CPL, TYPE_CPL, 14'd0, len};
      dw1 = {cid, status, 1'b0, byte_count};
      dw2 = {requester_id, tag, 1'b0, lower_addr};
      return {dw0, dw1, dw2};
   endfunction

endpackage

// File: rtl/tl_cpl_gen.sv
// Completion generator: latches a request, waits for CPLH/CPLD credits, then streams
// a 3DW-header completion as up to three 128-bit beats.
import tl_pkg::*;

module tl_cpl_gen #(
   parameter logic [15:0] COMPLETER_ID = 16'h0000,
   parameter int          MAX_DW       = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  cpl_gen_cmd_t cmd,
   input  tl_credit_t   credit_avail,
   output logic         cr_valid,
   output logic [7:0]   cr_cplh_dec,
   output logic [11:0]  cr_cpld_dec,
   output logic         tx_valid,
   input  logic         tx_ready,
   output tl_stream_t   tx,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, WAIT_CR, SEND} state_t;

   state_t       state_q, state_d;
   cpl_gen_cmd_t cmd_q;
   logic [9:0]   len_q, len_d;
   logic [1:0]   beat_q, beat_d;
   logic [1:0]   last_beat;
   logic [11:0]  cpld_need;
   logic [13:0]  nbytes;
   logic [11:0]  dw_raw;
   logic [95:0]  hdr;
   logic [3:0]   idx;
   logic [31:0]  pl [8];
   logic         unused_ok;

   assign unused_ok = ^{credit_avail.ph, credit_avail.pd, credit_avail.nph,
                        credit_avail.npd, cmd_q.has_data};

   // Length is derived from the incoming request and latched alongside it.
   always_comb begin
      nbytes = ((cmd.byte_count == 12'd0) ? 14'd4096 : {2'b00, cmd.byte_count})
               + {12'd0, cmd.lower_addr[1:0]} + 14'd3;
      dw_raw = 12'(nbytes >> 2);
      len_d  = 10'd0;
      if (cmd.has_data && cmd.cpl_status == CPL_SC)
         len_d = (dw_raw > 12'(MAX_DW)) ? 10'(MAX_DW) : dw_raw[9:0];
   end

   assign cpld_need = {4'd0, len_q[9:2] + {7'd0, |len_q[1:0]}};
   assign last_beat = (len_q <= 10'd1) ? 2'd0 : (len_q <= 10'd5) ? 2'd1 : 2'd2;
   assign busy      = (state_q != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cmd_q   <= '0;
         len_q   <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         if (cmd_valid && cmd_ready) begin
            cmd_q <= cmd;
            len_q <= len_d;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      cmd_ready   = 1'b0;
      cr_valid    = 1'b0;
      cr_cplh_dec = 8'd0;
      cr_cpld_dec = 12'd0;
      tx_valid    = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            beat_d    = 2'd0;
            if (cmd_valid) state_d = WAIT_CR;
         end
         WAIT_CR: begin
            if (credit_avail.cplh >= 8'd1 && credit_avail.cpld >= cpld_need) begin
               cr_valid    = 1'b1;
               cr_cplh_dec = 8'd1;
               cr_cpld_dec = cpld_need;
               state_d     = SEND;
            end
         end
         SEND: begin
            tx_valid = 1'b1;
            if (tx_ready) begin
               if (beat_q == last_beat) begin
                  beat_d  = 2'd0;
                  state_d = IDLE;
               end else begin
                  beat_d = beat_q + 2'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      for (int i = 0; i < 8; i++) pl[i] = cmd_q.data[32*i +: 32];
   end

   assign hdr = build_cpl_hdr(COMPLETER_ID, cmd_q.cpl_status, cmd_q.byte_count,
                              cmd_q.requester_id, cmd_q.tag, cmd_q.lower_addr, len_q);

   // Beat k>=1 carries payload DWs 4k-3..4k, lowest index in the top slot.
   always_comb begin
      tx  = '0;
      idx = 4'd0;
      if (state_q == SEND) begin
         tx.sop = (beat_q == 2'd0);
         tx.eop = (beat_q == last_beat);
         if (beat_q == 2'd0) begin
            tx.data = {hdr, (len_q != 10'd0) ? pl[0] : 32'd0};
            if (tx.eop) tx.be = {3'b111, len_q != 10'd0};
         end else begin
            for (int s = 0; s < 4; s++) begin
               idx = {beat_q, 2'b00} - 4'd3 + 4'(s);
               if ({6'd0, idx} < len_q) begin
                  tx.data[127-32*s -: 32] = pl[idx[2:0]];
                  if (tx.eop) tx.be[3-s] = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: doc/tl_cpl_gen.md
TL_CPL_GEN -- requirements
Module: tl_cpl_gen

Interface
REQ-001 SHALL have parameter COMPLETER_ID, default 16'h0000, Completer ID inserted in every completion header.
REQ-002 SHALL have parameter MAX_DW, default 8, fixed payload capacity in DWs (matches 256-bit cpl_gen_cmd_t.data).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  completion request valid.
REQ-006 SHALL have port cmd_ready  output  1  request accepted when cmd_valid&&cmd_ready.
REQ-007 SHALL have port cmd  input  cpl_gen_cmd_t  completion request.
REQ-008 SHALL have port credit_avail  input  tl_credit_t  available link credits; only cplh/cpld used.
REQ-009 SHALL have port cr_valid  output  1  one-cycle credit-consume pulse.
REQ-010 SHALL have port cr_cplh_dec  output  8  CPLH credits consumed (0/1).
REQ-011 SHALL have port cr_cpld_dec  output  12  CPLD credits consumed.
REQ-012 SHALL have port tx_valid  output  1  beat valid toward DLL.
REQ-013 SHALL have port tx_ready  input  1  DLL accepts beat when tx_valid&&tx_ready.
REQ-014 SHALL have port tx  output  tl_stream_t  outgoing beat; is_dllp always 0.
REQ-015 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-016 FSM SHALL have states IDLE, WAIT_CR, SEND; cmd_ready=1 only in IDLE; command registered on acceptance; IDLE->WAIT_CR next cycle.
REQ-017 If cpl_status!=0, has_data SHALL be treated as 0 (Cpl, no payload).
REQ-018 Payload length SHALL be LEN=min(MAX_DW, ceil((byte_count_eff+lower_addr[1:0])/4)), byte_count_eff=4096 when byte_count==0; LEN=0 when no data.
REQ-019 Credits needed SHALL be CPLH=1, CPLD=ceil(LEN/4) (0 when no data).
REQ-020 In WAIT_CR, when credit_avail.cplh>=1 and credit_avail.cpld>=CPLD, cr_valid SHALL pulse that cycle with dec values and FSM SHALL enter SEND; otherwise stay, outputs quiet.
REQ-021 tx_valid SHALL rise in the first SEND cycle (acceptance at N, credits ok at N+1 -> first beat N+2).
REQ-022 Header SHALL be 3DW: DW0={Fmt(010 CplD/000 Cpl),Type 01010,TC/attr 0,Length=LEN}; DW1={COMPLETER_ID,cpl_status,BCM=0,byte_count}; DW2={requester_id,tag,1'b0,lower_addr}.
REQ-023 Beat 0 SHALL carry data[127:96]=DW0,[95:64]=DW1,[63:32]=DW2,[31:0]=payload DW0 (or 0); beats k>=1 carry payload DWs 4k-3..4k, lower DW index at higher bits.
REQ-024 Beat count SHALL be 1 for LEN<=1, 2 for LEN 2..5, 3 for LEN 6..8; 2-bit beat counter increments on tx_valid&&tx_ready.
REQ-025 sop SHALL be 1 on beat 0 only; eop 1 on last beat only; be[i]=1 per valid DW of the final beat (be[3]=[127:96]), 0 on non-final beats.
REQ-026 While tx_valid&&!tx_ready, tx SHALL be held stable.
REQ-027 After eop beat accepted, FSM SHALL return to IDLE; cmd_ready high the following cycle.
REQ-028 Unused payload DWs in a beat SHALL be driven 0.

Reset
REQ-029 On rst, FSM SHALL go IDLE asynchronously; cmd_ready=1 after release; tx_valid, cr_valid, busy=0; tx, cr_cplh_dec, cr_cpld_dec=0.
REQ-030 Reset mid-SEND SHALL abandon the packet; no eop emitted; latched command discarded.

Structure
REQ-031 Completion Fmt/Type constants, cpl status codes (SC=0, UR=1, CA=2) and a header-builder function SHALL live in tl_pkg; cpl_gen_cmd_t, tl_stream_t, tl_credit_t used from tl_pkg.
REQ-032 Single module, no sub-modules.

Verification
REQ-033 SC CplD, COMPLETER_ID=0x0100, req 0x0200, tag 0x05, byte_count 4, lower_addr 0, data DW0 0xDEADBEEF -> one beat 0x4A000001_01000004_02000500_DEADBEEF, sop=eop=1, be=1111, cr dec 1/1.
REQ-034 byte_count 32, lower_addr 0 -> LEN 8, 3 beats, final be=1110, cr_cpld_dec=2.
REQ-035 cpl_status=1 (UR), has_data=1, byte_count 4 -> one beat DW0=0x0A000000, DW1=0x01002004, be=1110, cr_cpld_dec=0.
REQ-036 credit_avail.cplh=0 for 10 cycles -> no tx_valid, cr_valid low, busy=1; set cplh=1 -> cr_valid one cycle, beat next cycle.
REQ-037 tx_ready low 5 cycles on beat 1 of 3 -> tx unchanged, counter holds; completes with exactly one eop.
REQ-038 rst pulse during beat 1 -> tx_valid=0 immediately, IDLE, cmd_ready=1 after release, next command starts with sop.
